// File: rtl/rob_pkg.sv
// Shared types for the reorder scheduler: tracked-order record and FSM state encoding.
// Record widths match the default scheduler ID/length parameters.
package rob_pkg;

    localparam int ROB_ID_W  = 2;
    localparam int ROB_LEN_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ISSUE = 2'd2
    } state_e;

    typedef struct packed {
        logic [ROB_ID_W-1:0]  id;
        logic [ROB_LEN_W-1:0] len;
    } ord_info_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO; head word visible on rd_dat whenever not empty, pop advances it.
// Write/read latency 1 cycle; writes when full and pops when empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_rdy,
    output logic [WIDTH-1:0] rd_dat,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wr_en, rd_en;

    assign full   = (cnt_q == CNT_W'(DEPTH));
    assign empty  = (cnt_q == '0);
    assign wr_en  = wr_vld && !full;
    assign rd_en  = rd_rdy && !empty;
    assign rd_dat = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (wr_en) wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        if (rd_en) rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        if (wr_en && !rd_en) cnt_d = cnt_q + CNT_W'(1);
        if (rd_en && !wr_en) cnt_d = cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wr_dat;
    end

endmodule

// File: rtl/rob_ord_sched.sv
// Reserves per-ID reorder-buffer credits, then issues each request to its responder and the ROB.
// Accept-to-issue 2 cycles; stalls in WAIT without credits/tracker space, holds ISSUE until both handshakes.
module rob_ord_sched
    import rob_pkg::*;
#(
    parameter int ORD_DEPTH = 4,
    parameter int BUF_DEPTH = 16,
    parameter int ID_W      = $clog2(ORD_DEPTH),
    parameter int LEN_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ID_W-1:0]  req_id,
    input  logic [LEN_W-1:0] req_len,
    input  logic             req_vld,
    output logic             req_rdy,
    output logic [ID_W-1:0]  iss_id,
    output logic [LEN_W-1:0] iss_len,
    output logic             iss_vld,
    input  logic             iss_rdy,
    output logic [ID_W-1:0]  ord_id,
    output logic [LEN_W-1:0] ord_len,
    output logic             ord_vld,
    input  logic             ord_rdy,
    input  logic             fwd_hsk,
    output logic             err_len,
    output logic             err_drn
);

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int SUM_W = LEN_W + 2;

    state_e           state_q, state_d;
    ord_info_t        req_q, req_d;
    logic             ord_done_q, ord_done_d, iss_done_q, iss_done_d;
    logic             err_len_q, err_len_d, err_drn_q, err_drn_d;
    logic [LEN_W-1:0] beat_q, beat_d;
    logic [CNT_W-1:0] used_q [ORD_DEPTH];
    logic [CNT_W-1:0] used_d [ORD_DEPTH];

    ord_info_t        trk_head;
    logic             trk_full, trk_empty, trk_pop;
    logic [SUM_W-1:0] len_ext, need;
    logic             len_bad, credit_ok, rsv, rel;
    logic             ord_hs, iss_hs, both_done;

    // Credit check deliberately uses registered used_q: a same-cycle release is not seen.
    assign len_ext   = SUM_W'(req_q.len) + SUM_W'(1);
    assign len_bad   = len_ext > SUM_W'(BUF_DEPTH);
    assign need      = SUM_W'(used_q[req_q.id]) + len_ext;
    assign credit_ok = (need <= SUM_W'(BUF_DEPTH)) && !trk_full;
    assign rsv       = (state_q == ST_WAIT) && !len_bad && credit_ok;
    assign rel       = fwd_hsk && !trk_empty;
    assign trk_pop   = rel && (beat_q == trk_head.len);
    assign ord_hs    = ord_vld && ord_rdy;
    assign iss_hs    = iss_vld && iss_rdy;
    assign both_done = (ord_done_q || ord_hs) && (iss_done_q || iss_hs);

    sync_fifo #(
        .WIDTH (ID_W + LEN_W),
        .DEPTH (BUF_DEPTH)
    ) u_trk (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_vld (rsv),
        .wr_dat (req_q),
        .rd_rdy (trk_pop),
        .rd_dat (trk_head),
        .full   (trk_full),
        .empty  (trk_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (req_vld) state_d = ST_WAIT;
            ST_WAIT:  if (len_bad) state_d = ST_IDLE;
                      else if (credit_ok) state_d = ST_ISSUE;
            ST_ISSUE: if (both_done) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_rdy = (state_q == ST_IDLE);
        ord_vld = (state_q == ST_ISSUE) && !ord_done_q;
        iss_vld = (state_q == ST_ISSUE) && !iss_done_q;
        ord_id  = req_q.id;
        ord_len = req_q.len;
        iss_id  = req_q.id;
        iss_len = req_q.len;
        err_len = err_len_q;
        err_drn = err_drn_q;
    end

    always_comb begin
        req_d = req_q;
        if ((state_q == ST_IDLE) && req_vld) begin
            req_d.id  = req_id;
            req_d.len = req_len;
        end
        ord_done_d = (state_q == ST_ISSUE) && !both_done && (ord_done_q || ord_hs);
        iss_done_d = (state_q == ST_ISSUE) && !both_done && (iss_done_q || iss_hs);
        err_len_d  = (state_q == ST_WAIT) && len_bad;
        err_drn_d  = err_drn_q || (fwd_hsk && trk_empty);
        beat_d     = beat_q;
        if (rel) beat_d = trk_pop ? '0 : beat_q + LEN_W'(1);
        for (int i = 0; i < ORD_DEPTH; i++) begin
            used_d[i] = used_q[i];
            if (rsv && (req_q.id == ID_W'(i)))    used_d[i] = used_d[i] + CNT_W'(len_ext);
            if (rel && (trk_head.id == ID_W'(i))) used_d[i] = used_d[i] - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q      <= '0;
            ord_done_q <= 1'b0;
            iss_done_q <= 1'b0;
            err_len_q  <= 1'b0;
            err_drn_q  <= 1'b0;
            beat_q     <= '0;
            for (int i = 0; i < ORD_DEPTH; i++) used_q[i] <= '0;
        end else begin
            req_q      <= req_d;
            ord_done_q <= ord_done_d;
            iss_done_q <= iss_done_d;
            err_len_q  <= err_len_d;
            err_drn_q  <= err_drn_d;
            beat_q     <= beat_d;
            for (int i = 0; i < ORD_DEPTH; i++) used_q[i] <= used_d[i];
        end
    end

endmodule
